display_scan_driver: RTL and testbench

//  Receiving end of the multiplexed status/coordinate digit bus. Latches four 4-bit digit codes and

---
 rtl/display_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_display_scan_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// -----------------------------------------------------------------------------
// display_scan_driver
//
// Drives a 4-digit common-anode 7-segment display from four 4-bit digit codes.
// The digits are shown one at a time, in slots 0..3. Before each slot there is
// a short period with every digit off, which stops the previous digit from
// ghosting into the next one.
//
// New codes are loaded into a staging buffer. They are copied into the display
// buffer only at the end of slot 3, so a frame never shows old and new digits
// together.
//
// Ports:
//   clk         system clock; all logic runs on the rising edge
//   reset       synchronous, active-high reset
//   digit_data  {D3,D2,D1,D0}; D0 is shown in slot 0
//   load        1-cycle strobe that captures digit_data into the staging buffer
//   blank_mask  bit i = 1 keeps digit i dark during its slot (not buffered)
//   load_ack    1-cycle pulse when staged data is committed to the display
//   frame_tick  1-cycle pulse after the last clock of slot 3
//   scan_sel    index of the current slot
//   digit_en_n  active-low anode enables; at most one bit is low at a time
//   seg_n       active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module display_scan_driver #(
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digit_data,
   input  logic        load,
   input  logic [3:0]  blank_mask,
   output logic        load_ack,
   output logic        frame_tick,
   output logic [1:0]  scan_sel,
   output logic [3:0]  digit_en_n,
   output logic [6:0]  seg_n
);

   localparam int SHOW_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(PRESCALE - 1);
   localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   function automatic logic [6:0] hex_seg(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   state_t               state_q, state_d;
   logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
   logic [SHOW_W-1:0]    show_cnt_q, show_cnt_d;
   logic [1:0]           scan_q, scan_d;
   logic [15:0]          staging_q, staging_d;
   logic [15:0]          buf_q, buf_d;
   logic                 pending_q, pending_d;
   logic                 load_ack_q, load_ack_d;
   logic                 frame_tick_q, frame_tick_d;
   logic [3:0]           digit_en_n_q, digit_en_n_d;
   logic [6:0]           seg_n_q, seg_n_d;
   logic                 boundary;

   always_comb begin
      state_d      = state_q;
      blank_cnt_d  = blank_cnt_q;
      show_cnt_d   = show_cnt_q;
      scan_d       = scan_q;
      staging_d    = staging_q;
      buf_d        = buf_q;
      pending_d    = pending_q;
      boundary     = 1'b0;

      // Scan sequencer: blanking gap, then lit period, then advance slot.
      case (state_q)
         ST_BLANK: begin
            if (blank_cnt_q == BLANK_LAST) begin
               blank_cnt_d = '0;
               state_d     = ST_SHOW;
            end else begin
               blank_cnt_d = blank_cnt_q + BLANK_W'(1);
            end
         end
         default: begin
            if (show_cnt_q == SHOW_LAST) begin
               show_cnt_d = '0;
               scan_d     = scan_q + 2'd1;
               state_d    = ST_BLANK;
               boundary   = (scan_q == 2'd3);
            end else begin
               show_cnt_d = show_cnt_q + SHOW_W'(1);
            end
         end
      endcase

      // A load on the boundary cycle bypasses staging so it is not lost
      // behind the commit of older staged data.
      if (boundary) begin
         if (load) begin
            buf_d = digit_data;
         end else if (pending_q) begin
            buf_d = staging_q;
         end
         pending_d = 1'b0;
      end else if (load) begin
         staging_d = digit_data;
         pending_d = 1'b1;
      end

      load_ack_d   = boundary & (load | pending_q);
      frame_tick_d = boundary;

      // Outputs are registered from the next state. The buffer is committed
      // at the boundary, and at least one blanking clock follows before slot 0
      // is lit, so buf_q already holds the new frame here.
      digit_en_n_d = 4'hF;
      seg_n_d      = 7'h7F;
      if ((state_d == ST_SHOW) && !blank_mask[scan_d]) begin
         digit_en_n_d[scan_d] = 1'b0;
         seg_n_d              = hex_seg(buf_q[{scan_d, 2'b00} +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_BLANK;
         blank_cnt_q  <= '0;
         show_cnt_q   <= '0;
         scan_q       <= 2'd0;
         staging_q    <= 16'h0000;
         buf_q        <= 16'h0000;
         pending_q    <= 1'b0;
         load_ack_q   <= 1'b0;
         frame_tick_q <= 1'b0;
         digit_en_n_q <= 4'hF;
         seg_n_q      <= 7'h7F;
      end else begin
         state_q      <= state_d;
         blank_cnt_q  <= blank_cnt_d;
         show_cnt_q   <= show_cnt_d;
         scan_q       <= scan_d;
         staging_q    <= staging_d;
         buf_q        <= buf_d;
         pending_q    <= pending_d;
         load_ack_q   <= load_ack_d;
         frame_tick_q <= frame_tick_d;
         digit_en_n_q <= digit_en_n_d;
         seg_n_q      <= seg_n_d;
      end
   end

   assign load_ack   = load_ack_q;
   assign frame_tick = frame_tick_q;
   assign scan_sel   = scan_q;
   assign digit_en_n = digit_en_n_q;
   assign seg_n      = seg_n_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_display_scan_driver
//
// Testbench for display_scan_driver with PRESCALE=4 and BLANK_CYCLES=2. With
// these values a slot is 6 clocks and a frame is 24 clocks.
//
// For each frame it checks, the stimulus queues the expected outputs for every
// clock of that frame. The monitor tracks the frame number and the phase within
// the frame. It starts a new frame on frame_tick, or on the first clock after
// reset is applied. It pops and compares each queued entry when its
// frame/phase comes up.
// -----------------------------------------------------------------------------
module tb_display_scan_driver;

   logic        clk;
   logic        reset;
   logic [15:0] digit_data;
   logic        load;
   logic [3:0]  blank_mask;
   logic        load_ack;
   logic        frame_tick;
   logic [1:0]  scan_sel;
   logic [3:0]  digit_en_n;
   logic [6:0]  seg_n;

   display_scan_driver #(.PRESCALE(4), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .digit_data (digit_data),
      .load       (load),
      .blank_mask (blank_mask),
      .load_ack   (load_ack),
      .frame_tick (frame_tick),
      .scan_sel   (scan_sel),
      .digit_en_n (digit_en_n),
      .seg_n      (seg_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         frame;
      int         phase;
      logic [3:0] en;
      logic [6:0] seg;
      logic [1:0] scan;
      logic       tick;
      logic       ack;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         frame_no = 0;
   int         phase = 0;
   logic       rst_at_edge = 1'b0;
   logic       in_rst = 1'b0;
   logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Queue the expected outputs for all 24 clocks of frame f.
   task automatic push_frame(input int f, input logic [15:0] d, input logic [3:0] m,
                             input logic tick, input logic ack);
      exp_t r;
      for (int p = 0; p < 24; p++) begin
         int slot;
         int off;
         slot    = p / 6;
         off     = p % 6;
         r.frame = f;
         r.phase = p;
         r.scan  = slot[1:0];
         r.tick  = (p == 0) ? tick : 1'b0;
         r.ack   = (p == 0) ? ack : 1'b0;
         if (off < 2 || m[slot]) begin
            r.en  = 4'hF;
            r.seg = 7'h7F;
         end else begin
            r.en  = ~(4'b0001 << slot);
            r.seg = hex_tbl[d[slot*4 +: 4]];
         end
         exp_q.push_back(r);
      end
   endtask

   always @(posedge clk) rst_at_edge <= reset;

   // Monitor: track frame/phase, then retire any queued entry that is due.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_at_edge) begin
            if (!in_rst) frame_no++;
            in_rst = 1'b1;
            phase  = 0;
         end else begin
            in_rst = 1'b0;
            if (frame_tick === 1'b1) begin
               frame_no++;
               phase = 0;
            end else begin
               phase++;
            end
         end
         while (exp_q.size() > 0 &&
                (exp_q[0].frame < frame_no ||
                 (exp_q[0].frame == frame_no && exp_q[0].phase < phase))) begin
            checks++;
            errors++;
            $display("FAIL missed f%0d.p%0d: now at f%0d.p%0d, required that point to be reached",
                     exp_q[0].frame, exp_q[0].phase, frame_no, phase);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].frame == frame_no && exp_q[0].phase == phase) begin
            exp_t r;
            r = exp_q.pop_front();
            checks++;
            if ({digit_en_n, seg_n, scan_sel, frame_tick, load_ack} !==
                {r.en, r.seg, r.scan, r.tick, r.ack}) begin
               errors++;
               $display("FAIL f%0d.p%0d got en=%h seg=%h scan=%0d tick=%b ack=%b, want en=%h seg=%h scan=%0d tick=%b ack=%b",
                        r.frame, r.phase, digit_en_n, seg_n, scan_sel, frame_tick, load_ack,
                        r.en, r.seg, r.scan, r.tick, r.ack);
            end
         end
      end
   end

   // Advance to just after the negedge where the monitor reaches frame f, phase p.
   task automatic wait_phase(input int f, input int p);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge clk);
         #1;
         if (frame_no == f && phase == p) hit = 1'b1;
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL timeout waiting for f%0d.p%0d, at f%0d.p%0d", f, p, frame_no, phase);
      end
   endtask

   task automatic pulse_load(input logic [15:0] d);
      digit_data = d;
      load       = 1'b1;
      @(negedge clk);
      #1;
      load       = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      digit_data = 16'h0000;
      load       = 1'b0;
      blank_mask = 4'h0;

      // Reset for 3 cycles; frame 1 is the first frame after release.
      push_frame(1, 16'h0000, 4'h0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b0;

      // Load in the middle of a frame; commit at the next boundary.
      wait_phase(1, 10);
      push_frame(2, 16'h1234, 4'h0, 1'b1, 1'b1);
      pulse_load(16'h1234);

      // Two loads in one frame: the last one wins, and only one ack follows.
      wait_phase(2, 5);
      push_frame(3, 16'h5555, 4'h0, 1'b1, 1'b1);
      push_frame(4, 16'h5555, 4'h0, 1'b1, 1'b0);
      pulse_load(16'hAAAA);
      wait_phase(2, 12);
      pulse_load(16'h5555);

      // Mask digit 1 for all of frame 5.
      wait_phase(4, 10);
      push_frame(5, 16'h5555, 4'b0010, 1'b1, 1'b0);
      wait_phase(4, 23);
      blank_mask = 4'b0010;
      wait_phase(5, 23);
      blank_mask = 4'b0000;

      // Reset during slot 2 while data is pending: the pending data is discarded.
      wait_phase(6, 3);
      pulse_load(16'h9876);
      push_frame(7, 16'h0000, 4'h0, 1'b0, 1'b0);
      push_frame(8, 16'h0000, 4'h0, 1'b1, 1'b0);
      wait_phase(6, 14);
      reset = 1'b1;
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      reset = 1'b0;

      // Load on the boundary cycle itself, which takes the bypass path.
      wait_phase(8, 10);
      push_frame(9, 16'hBEEF, 4'h0, 1'b1, 1'b1);
      push_frame(10, 16'hBEEF, 4'h0, 1'b1, 1'b0);
      wait_phase(8, 23);
      pulse_load(16'hBEEF);

      wait_phase(10, 23);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover expected entries: %0d remain, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
